// File: rtl/ip_tx_pkg.sv
// Shared types and constants for the IPv4 transmit path.
package ip_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    IFG
  } sched_state_t;

  typedef enum logic {
    PROTO_UDP  = 1'b0,
    PROTO_ICMP = 1'b1
  } proto_t;

  localparam logic [7:0] IP_UDP_TYPE  = 8'h11;
  localparam logic [7:0] IP_ICMP_TYPE = 8'h01;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter (bit 0 = UDP, bit 1 = ICMP); a tie goes
// to the protocol that was not served last. Purely combinational.
module rr_arbiter_2
  import ip_tx_pkg::*;
(
  input  logic [1:0] req,
  input  proto_t     last,
  output logic [1:0] gnt,
  output logic       valid
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == PROTO_ICMP) ? 2'b01 : 2'b10;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/ip_tx_scheduler.sv
// Frame scheduler for the UDP/ICMP transmit path: arbitration, header and
// payload sequencing, inter-frame gap and a watchdog on stalled stages.
module ip_tx_scheduler
  import ip_tx_pkg::*;
#(
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        udp_req,
  input  logic [15:0] udp_len,
  output logic        udp_ack,
  output logic        udp_grant,
  input  logic        udp_done,
  input  logic        icmp_req,
  output logic        icmp_ack,
  output logic        icmp_grant,
  input  logic        icmp_done,
  output logic        eth_tx_start,
  output logic        icmp_sel,
  output logic [15:0] len_out,
  input  logic        ip_header_tx_udp_done,
  input  logic        ip_header_tx_icmp_done,
  output logic        busy,
  output logic        timeout_err
);

  localparam int IFG_W = (IFG_CYCLES > 2) ? $clog2(IFG_CYCLES) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  sched_state_t     state_q, state_d;
  logic [IFG_W-1:0] ifg_q, ifg_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  proto_t           last_q, last_d;
  proto_t           sel_q, sel_d;
  logic [15:0]      len_q, len_d;
  logic             udp_ack_q, udp_ack_d, icmp_ack_q, icmp_ack_d;
  logic             start_q, start_d, tmo_q, tmo_d;
  logic             udp_grant_q, udp_grant_d, icmp_grant_q, icmp_grant_d;
  logic             busy_q, busy_d;

  logic [1:0] arb_gnt;
  logic       arb_vld;
  logic       hdr_done, pay_done, wd_end;

  rr_arbiter_2 u_arb (
    .req   ({icmp_req, udp_req}),
    .last  (last_q),
    .gnt   (arb_gnt),
    .valid (arb_vld)
  );

  // Only the done pulse of the protocol owning this frame advances the FSM.
  assign hdr_done = (sel_q == PROTO_ICMP) ? ip_header_tx_icmp_done : ip_header_tx_udp_done;
  assign pay_done = (sel_q == PROTO_ICMP) ? icmp_done : udp_done;
  assign wd_end   = (wd_q == WD_LAST);

  always_comb begin
    state_d    = state_q;
    ifg_d      = ifg_q;
    wd_d       = wd_q;
    last_d     = last_q;
    sel_d      = sel_q;
    len_d      = len_q;
    udp_ack_d  = 1'b0;
    icmp_ack_d = 1'b0;
    start_d    = 1'b0;
    tmo_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          state_d = HDR;
          wd_d    = '0;
          start_d = 1'b1;
          if (arb_gnt[1]) begin
            sel_d      = PROTO_ICMP;
            len_d      = '0;
            icmp_ack_d = 1'b1;
          end else if (arb_gnt[0]) begin
            sel_d     = PROTO_UDP;
            len_d     = udp_len;
            udp_ack_d = 1'b1;
          end
        end
      end
      HDR: begin
        wd_d = wd_q + WD_W'(1);
        if (hdr_done) begin
          state_d = PAYLOAD;
        end else if (wd_end) begin
          state_d = IFG;
          ifg_d   = IFG_LOAD;
          last_d  = sel_q;
          tmo_d   = 1'b1;
        end
      end
      PAYLOAD: begin
        wd_d = wd_q + WD_W'(1);
        // A done pulse on the terminal count wins over the abort.
        if (pay_done || wd_end) begin
          state_d = IFG;
          ifg_d   = IFG_LOAD;
          last_d  = sel_q;
          tmo_d   = !pay_done;
        end
      end
      IFG: begin
        if (ifg_q == '0) begin
          state_d = IDLE;
        end else begin
          ifg_d = ifg_q - IFG_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    udp_grant_d  = (state_d == PAYLOAD) && (sel_d == PROTO_UDP);
    icmp_grant_d = (state_d == PAYLOAD) && (sel_d == PROTO_ICMP);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      ifg_q        <= '0;
      wd_q         <= '0;
      last_q       <= PROTO_ICMP;
      sel_q        <= PROTO_UDP;
      len_q        <= '0;
      udp_ack_q    <= 1'b0;
      icmp_ack_q   <= 1'b0;
      start_q      <= 1'b0;
      tmo_q        <= 1'b0;
      udp_grant_q  <= 1'b0;
      icmp_grant_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ifg_q        <= ifg_d;
      wd_q         <= wd_d;
      last_q       <= last_d;
      sel_q        <= sel_d;
      len_q        <= len_d;
      udp_ack_q    <= udp_ack_d;
      icmp_ack_q   <= icmp_ack_d;
      start_q      <= start_d;
      tmo_q        <= tmo_d;
      udp_grant_q  <= udp_grant_d;
      icmp_grant_q <= icmp_grant_d;
      busy_q       <= busy_d;
    end
  end

  assign udp_ack      = udp_ack_q;
  assign icmp_ack     = icmp_ack_q;
  assign eth_tx_start = start_q;
  assign timeout_err  = tmo_q;
  assign udp_grant    = udp_grant_q;
  assign icmp_grant   = icmp_grant_q;
  assign busy         = busy_q;
  assign icmp_sel     = (sel_q == PROTO_ICMP);
  assign len_out      = len_q;

endmodule

// File: doc/ip_tx_scheduler.md
# ip_tx_scheduler

Frame-level scheduler for the Ethernet/IPv4 transmit path. It arbitrates between the UDP transmit requester and the ICMP echo-reply requester, and starts the Ethernet header generator for the winner. It drives the protocol-select level that the IP header generator and checksum logic sample for the whole frame. It then hands the payload phase to the winner and enforces an inter-frame gap, with a watchdog so a stalled stage cannot lock the path.

## Interface
Parameters:
- IFG_CYCLES, 12: idle cycles inserted after every frame (≥1).
- TIMEOUT_CYCLES, 4096: maximum cycles allowed in HDR or PAYLOAD before abort (≥16).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; synchronous, active-low.
- udp_req  in  1  UDP frame pending; level, held until udp_ack.
- udp_len  in  16  UDP length; valid while udp_req=1.
- udp_ack  out  1  one-cycle pulse: UDP request accepted.
- udp_grant  out  1  level: UDP payload stage owns the byte stream.
- udp_done  in  1  pulse: UDP payload finished.
- icmp_req  in  1  ICMP reply pending; level, held until icmp_ack.
- icmp_ack  out  1  one-cycle pulse: ICMP request accepted.
- icmp_grant  out  1  level: ICMP payload stage owns the byte stream.
- icmp_done  in  1  pulse: ICMP payload finished.
- eth_tx_start  out  1  one-cycle pulse: start Ethernet header for the selected frame.
- icmp_sel  out  1  level: current frame is ICMP (0 = UDP); stable from eth_tx_start until return to IDLE.
- len_out  out  16  latched udp_len for the current frame; 0 for ICMP.
- ip_header_tx_udp_done  in  1  pulse from the IP header generator.
- ip_header_tx_icmp_done  in  1  pulse from the IP header generator.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, HDR, PAYLOAD, IFG.
- IDLE:
  - If any request is high, select the winner.
  - Arbitration:
    - Single request: it wins.
    - Both requests: the protocol not served last wins (round-robin).
    - `last_served` resets to ICMP, so UDP wins the first tie.
  - On selection:
    - Latch icmp_sel and len_out.
    - Pulse the winner's ack and eth_tx_start in the same cycle.
    - Go to HDR.
- HDR:
  - Wait for the IP header done pulse that matches icmp_sel.
  - A done pulse for the other protocol is ignored.
  - On the matching pulse, go to PAYLOAD.
- PAYLOAD:
  - The winner's grant is high for the whole state; the other grant stays 0.
  - On the matching payload done pulse: update last_served, go to IFG.
  - The non-matching done pulse is ignored.
- IFG:
  - Counter loads IFG_CYCLES−1 on entry and decrements.
  - At 0, go to IDLE.
  - Requests are not sampled during IFG.
- Watchdog:
  - Counter clears on entry to HDR and runs through HDR and PAYLOAD.
  - On reaching TIMEOUT_CYCLES−1: pulse timeout_err, drop grants, go to IFG.
  - last_served is still updated on abort, so the other requester gets the next tie.
- Requests:
  - A request that is still high in IDLE after its ack is treated as a new frame.
  - Requesters drop req on the cycle after ack.
- Reset values:
  - state IDLE; all counters 0; last_served ICMP.
  - udp_ack, icmp_ack, eth_tx_start, timeout_err, udp_grant, icmp_grant, busy, icmp_sel: 0.
  - len_out: 0.
- Reset mid-frame: everything returns to reset values on the next edge. No done pulse is required to recover.

## Timing
- All outputs are registered.
- Request high at edge N in IDLE → ack, eth_tx_start, busy, icmp_sel, len_out valid after edge N+1.
- eth_tx_start is exactly one cycle per frame.
- Header done at edge M → grant high after edge M+1.
- Payload done at edge P → grant low and state IFG after edge P+1.
- After IFG_CYCLES cycles in IFG → IDLE, busy=0.
- Earliest next ack is one cycle after that.
- A done pulse arriving in the same cycle as the watchdog terminal count is treated as done; no timeout_err.
- Back-to-back frames with continuous requests: eth_tx_start spacing = header + payload + IFG_CYCLES + 3 cycles.

## Structure
- Package ip_tx_pkg holds:
  - the state enum `sched_state_t` (IDLE, HDR, PAYLOAD, IFG);
  - the protocol enum `proto_t` (PROTO_UDP = 0, PROTO_ICMP = 1);
  - the shared constants IP_UDP_TYPE (8'h11) and IP_ICMP_TYPE (8'h01).
- Sub-module rr_arbiter_2: a two-requester round-robin arbiter.
  - Inputs: req[1:0], last.
  - Outputs: gnt[1:0], valid.
  - Combinational.
- The FSM, counters and output registers stay in ip_tx_scheduler.

## Test plan
- Single UDP, udp_len=16'h0020, IFG_CYCLES=12:
  - one udp_ack with eth_tx_start, icmp_sel=0, len_out=0x0020;
  - after the header done pulse, udp_grant high until udp_done;
  - busy drops exactly 12 cycles after udp_grant falls.
- Simultaneous udp_req and icmp_req from reset, both re-raised after each ack:
  - order is UDP, ICMP, UDP, ICMP;
  - icmp_frames have len_out=0 and icmp_sel=1.
- ICMP frame with a stray ip_header_tx_udp_done pulse in HDR:
  - state stays HDR;
  - icmp_grant rises only after ip_header_tx_icmp_done.
- TIMEOUT_CYCLES=64, udp_done never sent:
  - timeout_err pulses once 64 cycles after HDR entry;
  - grant drops, then IFG, then IDLE;
  - a pending icmp_req is served next.
- aresetn low during PAYLOAD:
  - next cycle, all outputs are at reset values;
  - after release, a new udp_req is acked normally.
- Requests held high during IFG:
  - no ack until IFG ends;
  - ack appears one cycle after busy falls.
